// File: rtl/ild1420_avg.sv
// Moving-average filter for ild1420 distance samples over a 2^LOG2_N window.
// Define ILD1420_AVG_TIMEOUT_EN to compile in the stale-data watchdog.
module ild1420_avg #(
   parameter int unsigned LOG2_N         = 3,
   parameter int unsigned TIMEOUT_CYCLES = 400000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] distance,
   input  logic [1:0]  error,
   input  logic        fresh,
   input  logic        clear,
   output logic [15:0] avg_distance,
   output logic        avg_valid,
   output logic        avg_update,
   output logic [15:0] reject_count,
   output logic        stale
);

   localparam int unsigned N  = 1 << LOG2_N;
   localparam int unsigned CW = LOG2_N + 1;
   localparam int unsigned SW = 16 + LOG2_N;

   typedef enum logic {StFill, StRun} state_e;

   state_e            state_q, state_d;
   logic [LOG2_N-1:0] ptr_q, ptr_d;
   logic [CW-1:0]     fill_q, fill_d;
   logic [SW-1:0]     sum_q, sum_d;
   logic [15:0]       avg_q, avg_d;
   logic              valid_q, valid_d;
   logic              upd_q, upd_d;
   logic [15:0]       rej_q, rej_d;
   logic              stale_q, stale_d;
   logic [15:0]       buf_q [N];

   logic        accept, reject, timeout;
   logic [15:0] evicted;

   // clear takes priority over a coincident fresh: the sample is neither stored nor rejected
   assign accept  = fresh && !clear && (error == 2'b00);
   assign reject  = fresh && !clear && (error != 2'b00);
   assign evicted = (state_q == StRun) ? buf_q[ptr_q] : 16'd0;

`ifdef ILD1420_AVG_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = tmo_q;
      if (fresh || clear) begin
         tmo_d = '0;
      end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // Fires once, on the cycle the counter reaches its saturation value
   assign timeout = !fresh && !clear && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      sum_d   = sum_q;
      avg_d   = avg_q;
      valid_d = valid_q;
      upd_d   = 1'b0;
      rej_d   = rej_q;
      stale_d = stale_q;
      if (clear) begin
         state_d = StFill;
         ptr_d   = '0;
         fill_d  = '0;
         sum_d   = '0;
         avg_d   = '0;
         valid_d = 1'b0;
         rej_d   = '0;
         stale_d = 1'b0;
      end else if (accept) begin
         ptr_d   = ptr_q + 1'b1;
         sum_d   = sum_q + SW'(distance) - SW'(evicted);
         stale_d = 1'b0;
         if (state_q == StFill) begin
            fill_d = fill_q + 1'b1;
            if (fill_d == CW'(N)) begin
               state_d = StRun;
            end
         end
         if (state_d == StRun) begin
            avg_d   = 16'(sum_d >> LOG2_N);
            upd_d   = 1'b1;
            valid_d = 1'b1;
         end
      end else if (reject) begin
         if (rej_q != 16'hFFFF) begin
            rej_d = rej_q + 1'b1;
         end
      end else if (timeout) begin
         state_d = StFill;
         ptr_d   = '0;
         fill_d  = '0;
         sum_d   = '0;
         avg_d   = '0;
         valid_d = 1'b0;
         stale_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFill;
         ptr_q   <= '0;
         fill_q  <= '0;
         sum_q   <= '0;
         avg_q   <= '0;
         valid_q <= 1'b0;
         upd_q   <= 1'b0;
         rej_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         fill_q  <= fill_d;
         sum_q   <= sum_d;
         avg_q   <= avg_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
         rej_q   <= rej_d;
         stale_q <= stale_d;
      end
   end

   // Sample storage needs no reset: entries are only read once the fill counter covers them
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q[ptr_q] <= distance;
      end
   end

   assign avg_distance = avg_q;
   assign avg_valid    = valid_q;
   assign avg_update   = upd_q;
   assign reject_count = rej_q;
   assign stale        = stale_q;

endmodule

// File: tb/tb_ild1420_avg.sv
// Directed self-checking bench for ild1420_avg (LOG2_N=2, TIMEOUT_CYCLES=1000).
module tb_ild1420_avg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] distance = '0;
   logic [1:0]  error = '0;
   logic        fresh = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] avg_distance;
   logic        avg_valid;
   logic        avg_update;
   logic [15:0] reject_count;
   logic        stale;

   int n_checks = 0;
   int n_pass   = 0;

   ild1420_avg #(
      .LOG2_N         (2),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .distance     (distance),
      .error        (error),
      .fresh        (fresh),
      .clear        (clear),
      .avg_distance (avg_distance),
      .avg_valid    (avg_valid),
      .avg_update   (avg_update),
      .reject_count (reject_count),
      .stale        (stale)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One-cycle fresh pulse; returns at the negedge after the sampling edge
   task automatic send(input logic [15:0] d, input logic [1:0] e);
      @(negedge clk);
      fresh    = 1'b1;
      distance = d;
      error    = e;
      @(negedge clk);
      fresh    = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_avg", avg_distance, 0);
      check("rst_valid", avg_valid, 0);
      check("rst_upd", avg_update, 0);
      check("rst_rej", reject_count, 0);
      check("rst_stale", stale, 0);
      rst_n = 1'b1;

      // Fill the window
      send(100, 0);
      check("fill1_upd", avg_update, 0);
      check("fill1_avg", avg_distance, 0);
      send(200, 0);
      check("fill2_upd", avg_update, 0);
      send(300, 0);
      check("fill3_upd", avg_update, 0);
      check("fill3_valid", avg_valid, 0);
      send(400, 0);
      check("full_upd", avg_update, 1);
      check("full_avg", avg_distance, 250);
      check("full_valid", avg_valid, 1);
      @(negedge clk);
      check("upd_pulse_end", avg_update, 0);

      // Slide, then an error sample
      send(500, 0);
      check("slide_avg", avg_distance, 350);
      check("slide_upd", avg_update, 1);
      send(9999, 2);
      check("err_rej", reject_count, 1);
      check("err_avg", avg_distance, 350);
      check("err_upd", avg_update, 0);

      // Back-to-back maximum samples
      @(negedge clk);
      fresh    = 1'b1;
      distance = 16'hFFFF;
      error    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 3) fresh = 1'b0;
         check("b2b_upd", avg_update, 1);
      end
      check("b2b_avg", avg_distance, 65535);
      @(negedge clk);
      check("b2b_upd_end", avg_update, 0);

      // Clear wins over a coincident fresh
      @(negedge clk);
      clear    = 1'b1;
      fresh    = 1'b1;
      distance = 1234;
      @(negedge clk);
      clear = 1'b0;
      fresh = 1'b0;
      check("clr_valid", avg_valid, 0);
      check("clr_avg", avg_distance, 0);
      check("clr_rej", reject_count, 0);
      check("clr_upd", avg_update, 0);
      send(1, 0);
      send(2, 0);
      send(3, 0);
      check("clr_fill_valid", avg_valid, 0);
      send(5, 0);
      check("clr_refill_avg", avg_distance, 2);
      check("clr_refill_valid", avg_valid, 1);

`ifdef ILD1420_AVG_TIMEOUT_EN
      repeat (990) @(negedge clk);
      check("pre_tmo_stale", stale, 0);
      check("pre_tmo_valid", avg_valid, 1);
      repeat (15) @(negedge clk);
      check("tmo_stale", stale, 1);
      check("tmo_valid", avg_valid, 0);
      check("tmo_avg", avg_distance, 0);
      send(9999, 1);
      check("tmo_err_stale", stale, 1);
      check("tmo_err_rej", reject_count, 1);
      send(42, 0);
      check("tmo_fresh_stale", stale, 0);
      check("tmo_fresh_valid", avg_valid, 0);
      send(2, 0);
      send(4, 0);
      send(8, 0);
      check("tmo_refill_avg", avg_distance, 14);
      check("tmo_refill_valid", avg_valid, 1);
`endif

      // Reset mid-window discards buffered samples
      send(7, 0);
      send(9, 0);
      send(3, 3);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_avg", avg_distance, 0);
      check("mid_rst_valid", avg_valid, 0);
      check("mid_rst_rej", reject_count, 0);
      check("mid_rst_stale", stale, 0);
      rst_n = 1'b1;
      send(10, 0);
      send(20, 0);
      send(30, 0);
      check("post_rst_fill_valid", avg_valid, 0);
      check("post_rst_fill_upd", avg_update, 0);
      send(40, 0);
      check("post_rst_avg", avg_distance, 25);
      check("post_rst_valid", avg_valid, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
